// File: rtl/palette_lut_pipe_if.sv
// rtl/palette_lut_pipe_if.sv - pixel, palette-write and RGB signal bundle for palette_lut_pipe
interface palette_lut_pipe_if #(
  parameter int IDX_W = 4,
  parameter int CH_W  = 8
);
  logic                 wr_en;
  logic [IDX_W-1:0]     wr_addr;
  logic [3*CH_W-1:0]    wr_data;
  logic                 frame_start;
  logic                 pix_valid;
  logic                 ch_on;
  logic [IDX_W-1:0]     fg_idx;
  logic [IDX_W-1:0]     bg_idx;
  logic                 blink_en;
  logic                 out_valid;
  logic [CH_W-1:0]      red;
  logic [CH_W-1:0]      green;
  logic [CH_W-1:0]      blue;
  logic                 blink_phase;

  modport master (
    output wr_en, wr_addr, wr_data, frame_start,
    output pix_valid, ch_on, fg_idx, bg_idx, blink_en,
    input  out_valid, red, green, blue, blink_phase
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, frame_start,
    input  pix_valid, ch_on, fg_idx, bg_idx, blink_en,
    output out_valid, red, green, blue, blink_phase
  );
endinterface

// File: rtl/palette_lut_pipe.sv
// rtl/palette_lut_pipe.sv - two-stage fg/bg palette lookup with run-time writes and frame blink
module palette_lut_pipe #(
  parameter int IDX_W        = 4,
  parameter int CH_W         = 8,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  palette_lut_pipe_if.slave     bus
);
  localparam int DEPTH = 2 ** IDX_W;
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  // 8-bit default channel value aligned into CH_W: left-aligned when wider, top bits when narrower
  function automatic logic [CH_W-1:0] chan_fit(input logic [7:0] v);
    logic [CH_W+7:0] t;
    t = {v, {CH_W{1'b0}}};
    return t[CH_W+7 -: CH_W];
  endfunction

  function automatic logic [3*CH_W-1:0] default_entry(input int unsigned idx);
    logic [23:0] rgb8;
    case (idx)
      0:       rgb8 = 24'h3399FF;
      1:       rgb8 = 24'hFFFFFF;
      2:       rgb8 = 24'h000000;
      3:       rgb8 = 24'h339900;
      4:       rgb8 = 24'h993300;
      5:       rgb8 = 24'hFF0000;
      6:       rgb8 = 24'hC0C0C0;
      7:       rgb8 = 24'h808080;
      default: rgb8 = 24'h000000;
    endcase
    return {chan_fit(rgb8[23:16]), chan_fit(rgb8[15:8]), chan_fit(rgb8[7:0])};
  endfunction

  logic [3*CH_W-1:0] r_pal [DEPTH];
  logic [CNT_W-1:0]  r_frame_cnt;
  logic              r_blink_phase;
  logic              r_valid1;
  logic [IDX_W-1:0]  r_sel;
  logic              r_out_valid;
  logic [3*CH_W-1:0] r_rgb;

  logic              w_use_fg;
  logic [IDX_W-1:0]  w_sel;
  logic [3*CH_W-1:0] w_rd_data;

  // Palette table; writes land at the edge so a same-cycle stage-2 read sees the old entry
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pal[i] <= default_entry(i);
      end
    end else if (bus.wr_en) begin
      r_pal[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (bus.frame_start) begin
      if (r_frame_cnt == CNT_LAST) begin
        r_frame_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  // Blinking foreground pixels fall back to background during the active phase
  always_comb begin
    w_use_fg = bus.ch_on && !(bus.blink_en && r_blink_phase);
    w_sel    = w_use_fg ? bus.fg_idx : bus.bg_idx;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid1 <= 1'b0;
      r_sel    <= '0;
    end else begin
      r_valid1 <= bus.pix_valid;
      r_sel    <= w_sel;
    end
  end

  assign w_rd_data = r_pal[r_sel];

  // Blank cycles force black so the DAC never replays a stale colour
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_valid <= 1'b0;
      r_rgb       <= '0;
    end else if (r_valid1) begin
      r_out_valid <= 1'b1;
      r_rgb       <= w_rd_data;
    end else begin
      r_out_valid <= 1'b0;
      r_rgb       <= '0;
    end
  end

  assign bus.out_valid   = r_out_valid;
  assign bus.red         = r_rgb[3*CH_W-1 -: CH_W];
  assign bus.green       = r_rgb[2*CH_W-1 -: CH_W];
  assign bus.blue        = r_rgb[CH_W-1:0];
  assign bus.blink_phase = r_blink_phase;
endmodule

// File: doc/palette_lut_pipe.md
Name: palette_lut_pipe

Overview:
Programmable foreground/background colour palette for the VGA text renderer. It sits between the glyph/attribute fetch and the VGA DAC outputs. Each pixel carries a glyph "on" bit plus per-character foreground and background palette indices, and the block returns registered RGB after a fixed 2-cycle latency. The palette is writable at run time and supports a frame-synchronous blink attribute.

Parameters:
IDX_W, 4, palette index width; table depth = 2**IDX_W entries (IDX_W >= 3)
CH_W, 8, bits per colour channel
BLINK_FRAMES, 30, frame_start pulses per blink half-period (>= 1)

Ports:
Clk  in  1  system clock, all state on rising edge
Reset  in  1  asynchronous, active-high reset
wr_en  in  1  palette write strobe, one entry per cycle
wr_addr  in  IDX_W  entry to write
wr_data  in  3*CH_W  {red, green, blue}, red in MSBs
frame_start  in  1  one-cycle pulse at start of each frame
pix_valid  in  1  pixel request valid (low = blanking)
ch_on  in  1  glyph pixel is foreground
fg_idx  in  IDX_W  foreground palette index
bg_idx  in  IDX_W  background palette index
blink_en  in  1  character has blink attribute
out_valid  out  1  RGB outputs valid
red  out  CH_W  red channel
green  out  CH_W  green channel
blue  out  CH_W  blue channel
blink_phase  out  1  current blink phase, for status/debug

Behaviour:
- Reset, asynchronous and active-high, sets the following:
  - out_valid=0; red/green/blue=0; blink_phase=0; frame counter=0; both pipeline stages invalid.
  - Palette loads the default table (8-bit values): 0=33/99/FF, 1=FF/FF/FF, 2=00/00/00, 3=33/99/00, 4=99/33/00, 5=FF/00/00, 6=C0/C0/C0, 7=80/80/80; entries 8 and up = 00/00/00.
  - CH_W>8: each 8-bit default is left-aligned, low bits zero. CH_W<8: the top CH_W bits are kept.
- Reset mid-operation aborts in-flight pixels (no out_valid for them), restores the defaults and discards pending writes.
- Stage 1 (cycle N, pix_valid=1):
  - Registers the selected index: sel = (ch_on && !(blink_en && blink_phase)) ? fg_idx : bg_idx.
  - Registers valid1=pix_valid.
- Stage 2 (cycle N+1):
  - Reads the palette at sel and registers it to red/green/blue.
  - Registers out_valid=valid1. Outputs are visible at cycle N+2.
- Blanking: when a stage-2 valid is 0, red/green/blue register to 0 and out_valid=0. Outputs never hold stale colour.
- Throughput: 1 pixel/cycle, no stall or back-pressure. pix_valid may toggle every cycle.
- Palette write:
  - On wr_en, entry wr_addr takes wr_data at the clock edge.
  - A stage-2 read in the same cycle as a write to the same entry returns the old value. The new value is returned from the next cycle on.
- Blink counter:
  - On frame_start, if counter==BLINK_FRAMES-1: counter<=0 and blink_phase toggles. Otherwise counter increments.
  - blink_phase is sampled by stage 1 in the same cycle it is used. A toggle takes effect for pixels entering stage 1 after the edge.
- Simultaneous events are independent and all take effect in the same cycle: frame_start, wr_en and pix_valid.
- Index arithmetic is unsigned. There are no out-of-range indices, since depth = 2**IDX_W.

Test Plan:
- Reset, then pix_valid=1, ch_on=1, fg_idx=5 at cycle 0 -> at cycle 2 out_valid=1, RGB=FF/00/00. With ch_on=0, bg_idx=0 -> 33/99/FF.
- Back-to-back: fg_idx = 1,2,6,7 on consecutive cycles with ch_on=1 -> FFFFFF, 000000, C0C0C0, 808080 on consecutive cycles 2 later. A pix_valid=0 gap gives out_valid=0 and RGB=0.
- Write entry 9 = 12/34/56 at cycle 0 while a pixel reading index 9 is in stage 2 -> that pixel returns 00/00/00. A pixel entering stage 1 at cycle 0 returns 12/34/56.
- BLINK_FRAMES=2, blink_en=1, ch_on=1, fg=1, bg=2:
  - Before any frame_start -> FFFFFF.
  - After 2 frame_start pulses, blink_phase=1 -> 000000.
  - After 4 pulses -> FFFFFF.
  - blink_en=0 -> always FFFFFF.
- Assert Reset while 2 pixels are in flight and after entry 3 was rewritten -> no out_valid for the in-flight pixels. After release, index 3 returns 33/99/00 and blink_phase=0.
- Run with IDX_W=3 and CH_W=4 -> defaults truncate, e.g. entry 0 = 3/9/F, entry 6 = C/C/C. Latency is still 2.
